// File: rtl/result_serializer.sv
// Serializes a tile of NUM_RES signed 16-bit results into bytes under a host ack handshake.
// Optional RESULT_SATURATE_EN sends each result as one saturated int8 byte instead of two.
module result_serializer #(
    parameter int NUM_RES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  res_valid,
    input  logic [NUM_RES*16-1:0] res_data,
    output logic                  res_ready,
    input  logic                  host_ack,
    output logic [7:0]            dout,
    output logic                  dout_valid,
    output logic                  done
);

`ifdef RESULT_SATURATE_EN
    localparam int NUM_BYTES = NUM_RES;
`else
    localparam int NUM_BYTES = NUM_RES * 2;
`endif
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_r;
    logic [IDX_W-1:0]        idx_r;
    logic [NUM_RES*16-1:0]   buf_r;
    logic [7:0]              dout_r;
    logic                    done_r;

`ifdef RESULT_SATURATE_EN
    function automatic logic [7:0] sat8(input logic signed [15:0] v);
        logic [7:0] r;
        if (v > 16'sd127) begin
            r = 8'h7F;
        end else if (v < -16'sd128) begin
            r = 8'h80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction
`endif

    // Packed results are little-endian per result, so in 16-bit mode byte k is simply bits [8k+7:8k].
    function automatic logic [7:0] byte_at(input logic [NUM_RES*16-1:0] tile,
                                           input logic [IDX_W-1:0]      k);
`ifdef RESULT_SATURATE_EN
        return sat8(tile[int'(k)*16 +: 16]);
`else
        return tile[int'(k)*8 +: 8];
`endif
    endfunction

    // Handshake FSM: latch a tile in IDLE, step through its bytes on each ack in SEND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= {IDX_W{1'b0}};
            buf_r   <= {(NUM_RES*16){1'b0}};
            dout_r  <= 8'h00;
            done_r  <= 1'b0;
        end else if (ena) begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (res_valid) begin
                        buf_r   <= res_data;
                        idx_r   <= {IDX_W{1'b0}};
                        dout_r  <= byte_at(res_data, {IDX_W{1'b0}});
                        state_r <= SEND;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SEND: begin
                    if (host_ack) begin
                        if (idx_r == LAST_IDX) begin
                            state_r <= IDLE;
                            idx_r   <= {IDX_W{1'b0}};
                            dout_r  <= 8'h00;
                            done_r  <= 1'b1;
                        end else begin
                            idx_r  <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                            dout_r <= byte_at(buf_r, idx_r + {{(IDX_W-1){1'b0}}, 1'b1});
                        end
                    end else begin
                        state_r <= SEND;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= {IDX_W{1'b0}};
                end
            endcase
        end else begin
            done_r <= 1'b0;
        end
    end

    assign res_ready  = (state_r == IDLE);
    assign dout_valid = (state_r == SEND);
    assign dout       = dout_r;
    assign done       = done_r;

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench for result_serializer: a byte-list reference model feeds a queue checked by a monitor.
// Honours RESULT_SATURATE_EN the same way as the design.
module tb_result_serializer;

    localparam int NUM_RES = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  ena;
    logic                  res_valid;
    logic [NUM_RES*16-1:0] res_data;
    logic                  res_ready;
    logic                  host_ack;
    logic [7:0]            dout;
    logic                  dout_valid;
    logic                  done;

    int checks;
    int errors;

    logic [7:0] exp_q[$];
    bit         busy;
    bit         done_exp;

    result_serializer #(.NUM_RES(NUM_RES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .host_ack   (host_ack),
        .dout       (dout),
        .dout_valid (dout_valid),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the list of bytes the host should see for one tile.
    task automatic push_tile(input logic [NUM_RES*16-1:0] tile);
        for (int r = 0; r < NUM_RES; r++) begin
            int v;
            v = int'($signed(tile[r*16 +: 16]));
`ifdef RESULT_SATURATE_EN
            if (v > 127)       exp_q.push_back(8'h7F);
            else if (v < -128) exp_q.push_back(8'h80);
            else               exp_q.push_back(8'(v & 255));
`else
            exp_q.push_back(8'(v & 255));
            exp_q.push_back(8'((v >> 8) & 255));
`endif
        end
    endtask

    // Monitor: compare outputs mid-cycle, then predict the effect of the upcoming edge.
    initial begin
        busy = 1'b0;
        done_exp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                busy = 1'b0;
                done_exp = 1'b0;
            end else begin
                check("res_ready", 32'(res_ready), 32'(!busy));
                check("dout_valid", 32'(dout_valid), 32'(busy));
                check("done", 32'(done), 32'(done_exp));
                done_exp = 1'b0;
                if (busy) begin
                    if (exp_q.size() == 0) begin
                        check("queue_underflow", 32'd1, 32'd0);
                        busy = 1'b0;
                    end else begin
                        check("dout", 32'(dout), 32'(exp_q[0]));
                        if (ena && host_ack) begin
                            void'(exp_q.pop_front());
                            if (exp_q.size() == 0) begin
                                busy = 1'b0;
                                done_exp = 1'b1;
                            end
                        end
                    end
                end else if (ena && res_valid) begin
                    push_tile(res_data);
                    busy = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NUM_RES*16-1:0] tile_a;
        logic [NUM_RES*16-1:0] tile_b;
        int cnt;
        checks = 0;
        errors = 0;
        rst_n = 1'b0; ena = 1'b0; res_valid = 1'b0; host_ack = 1'b0;
        res_data = {(NUM_RES*16){1'b0}};
        #1;
        check("rst_res_ready", 32'(res_ready), 32'd1);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        tick(); tick();
        rst_n = 1'b1;

        // Basic burst with ack held high, accepted on first enabled edge after reset.
        ena = 1'b1; host_ack = 1'b1; res_valid = 1'b1;
        res_data = {16'h0708, 16'h0506, 16'h0304, 16'h0102};
        tick();
        res_valid = 1'b0;
        repeat (12) tick();

        // Ack stalls 1,0,0 pattern.
        res_valid = 1'b1; host_ack = 1'b0;
        res_data = {16'hFFFF, 16'h0005, 16'hFED4, 16'h012C};
        tick();
        res_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            host_ack = (i % 3 == 0);
            tick();
        end

        // Busy rejection: tile_b offered throughout tile_a's burst.
        tile_a = {16'h8000, 16'h7FFF, 16'h0080, 16'hFF7F};
        tile_b = {16'h1234, 16'hABCD, 16'h00FF, 16'hFF00};
        host_ack = 1'b1; res_valid = 1'b1; res_data = tile_a;
        tick();
        res_data = tile_b;
        repeat (10) tick();
        res_valid = 1'b0;
        repeat (10) tick();

        // ena gating mid-burst with ack high.
        res_valid = 1'b1; res_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        tick();
        res_valid = 1'b0;
        repeat (3) tick();
        ena = 1'b0;
        repeat (5) tick();
        ena = 1'b1;
        repeat (10) tick();

        // Reset in the middle of a burst.
        res_valid = 1'b1; host_ack = 1'b1; res_data = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A};
        tick();
        res_valid = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_dout_valid", 32'(dout_valid), 32'd0);
        check("midrst_res_ready", 32'(res_ready), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            ena = ($urandom_range(0, 9) != 0);
            host_ack = $urandom_range(0, 1) == 1;
            res_valid = $urandom_range(0, 3) == 0;
            res_data = {$urandom(), $urandom()};
            tick();
        end

        // Drain remaining bytes.
        ena = 1'b1; host_ack = 1'b1; res_valid = 1'b0;
        cnt = 0;
        while ((busy || exp_q.size() != 0) && cnt < 50) begin
            tick();
            cnt++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
